// File: rtl/systolic_feeder_if.sv
// Operand-feeder bus: K-slice input handshake, skewed operand outputs and pass status.
interface systolic_feeder_if #(
    parameter int N      = 4,
    parameter int DATA_W = 8,
    parameter int K_MAX  = 256,
    parameter int KW     = $clog2(K_MAX + 1)
);
    logic                  start_i;
    logic [KW-1:0]         k_len_i;
    logic                  in_valid_i;
    logic                  in_ready_o;
    logic [N*DATA_W-1:0]   a_col_i;
    logic [N*DATA_W-1:0]   b_row_i;
    logic [N*DATA_W-1:0]   a_o;
    logic [N*DATA_W-1:0]   b_o;
    logic                  busy_o;
    logic                  done_o;
    logic [15:0]           bubble_cnt_o;

    // slave: the feeder itself; master: whoever supplies slices and watches status
    modport slave (
        input  start_i, k_len_i, in_valid_i, a_col_i, b_row_i,
        output in_ready_o, a_o, b_o, busy_o, done_o, bubble_cnt_o
    );

    modport master (
        output start_i, k_len_i, in_valid_i, a_col_i, b_row_i,
        input  in_ready_o, a_o, b_o, busy_o, done_o, bubble_cnt_o
    );
endinterface

// File: rtl/systolic_feeder.sv
// Skewed operand feeder for an NxN systolic array; sequences one matrix pass per start.
// Optional stall counter enabled by defining FEEDER_BUBBLE_CNT_EN.
//
// state   | meaning
// S_IDLE  | waiting for start_i
// S_FEED  | accepting K slices, in_ready_o high
// S_FLUSH | injecting 2N-2 zero beats so the last slice reaches PE[N-1][N-1]
// S_DONE  | one-cycle completion pulse
module systolic_feeder #(
    parameter int N      = 4,
    parameter int DATA_W = 8,
    parameter int K_MAX  = 256,
    parameter int KW     = $clog2(K_MAX + 1)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    systolic_feeder_if.slave   bus
);
    localparam int FW         = (N > 1) ? $clog2(2 * N) : 1;
    localparam int FLUSH_LAST = (N > 1) ? 2 * N - 3 : 0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FEED,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    logic [KW-1:0]   kcnt_q, kcnt_d;
    logic [FW-1:0]   fcnt_q, fcnt_d;
    logic            busy_q, busy_d;
    logic            accept;
    logic            start_acc;
    logic [KW-1:0]   k_clamped;

    logic [N*DATA_W-1:0] a_out;
    logic [N*DATA_W-1:0] b_out;

    assign k_clamped = (bus.k_len_i > KW'(K_MAX)) ? KW'(K_MAX) : bus.k_len_i;
    assign accept    = bus.in_valid_i && (state_q == S_FEED);
    assign start_acc = bus.start_i && (state_q == S_IDLE);

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        kcnt_d  = kcnt_q;
        fcnt_d  = fcnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start_i) begin
                    k_d    = k_clamped;
                    kcnt_d = '0;
                    state_d = (k_clamped == '0) ? S_DONE : S_FEED;
                end
            end
            S_FEED: begin
                if (accept) begin
                    kcnt_d = kcnt_q + KW'(1);
                    if (kcnt_q == k_q - KW'(1)) begin
                        fcnt_d  = '0;
                        state_d = (N == 1) ? S_DONE : S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                fcnt_d = fcnt_q + FW'(1);
                if (fcnt_q == FW'(FLUSH_LAST)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d == S_FEED) || (state_d == S_FLUSH);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            kcnt_q  <= '0;
            fcnt_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            kcnt_q  <= kcnt_d;
            fcnt_q  <= fcnt_d;
            busy_q  <= busy_d;
        end
    end

    // Lane i is a chain of i+1 registers; idle cycles push zeros so lanes stay aligned.
    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [DATA_W-1:0] a_sr_q [0:i];
        logic [DATA_W-1:0] b_sr_q [0:i];

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                for (int s = 0; s <= i; s++) begin
                    a_sr_q[s] <= '0;
                    b_sr_q[s] <= '0;
                end
            end else begin
                a_sr_q[0] <= accept ? bus.a_col_i[i*DATA_W +: DATA_W] : '0;
                b_sr_q[0] <= accept ? bus.b_row_i[i*DATA_W +: DATA_W] : '0;
                for (int s = 1; s <= i; s++) begin
                    a_sr_q[s] <= a_sr_q[s-1];
                    b_sr_q[s] <= b_sr_q[s-1];
                end
            end
        end

        assign a_out[i*DATA_W +: DATA_W] = a_sr_q[i];
        assign b_out[i*DATA_W +: DATA_W] = b_sr_q[i];
    end

    assign bus.a_o        = a_out;
    assign bus.b_o        = b_out;
    assign bus.in_ready_o = (state_q == S_FEED);
    assign bus.busy_o     = busy_q;
    assign bus.done_o     = (state_q == S_DONE);

`ifdef FEEDER_BUBBLE_CNT_EN
    logic [15:0] bubble_q, bubble_d;

    always_comb begin
        bubble_d = bubble_q;
        if (start_acc) begin
            bubble_d = '0;
        end else if ((state_q == S_FEED) && !bus.in_valid_i && (bubble_q != 16'hFFFF)) begin
            bubble_d = bubble_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bubble_q <= '0;
        end else begin
            bubble_q <= bubble_d;
        end
    end

    assign bus.bubble_cnt_o = bubble_q;
`else
    logic unused_start_acc;
    assign unused_start_acc = start_acc;
    assign bus.bubble_cnt_o = 16'h0;
`endif

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder (N=4, DATA_W=8, K_MAX=256).
module tb_systolic_feeder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    systolic_feeder_if #(.N(4), .DATA_W(8), .K_MAX(256)) bus ();

    systolic_feeder #(.N(4), .DATA_W(8), .K_MAX(256)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.start_i    = 1'b0;
        bus.k_len_i    = '0;
        bus.in_valid_i = 1'b0;
        bus.a_col_i    = '0;
        bus.b_row_i    = '0;
    endtask

    logic [31:0] exp_v;
    int          ready_cnt, busy_cnt, done_cnt, done_cyc;
    logic [15:0] exp_bub;

    initial begin
        clear_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check("rst_ready", bus.in_ready_o, 0);
        check("rst_busy",  bus.busy_o, 0);
        check("rst_done",  bus.done_o, 0);
        check("rst_a",     bus.a_o, 0);
        check("rst_b",     bus.b_o, 0);
        check("rst_bub",   bus.bubble_cnt_o, 0);

        // 1: single slice, lane i shows i+1 in cycle t+1+i
        bus.start_i = 1'b1;
        bus.k_len_i = 9'd1;
        step();
        bus.start_i = 1'b0;
        check("t1_ready", bus.in_ready_o, 1);
        check("t1_busy",  bus.busy_o, 1);
        bus.in_valid_i = 1'b1;
        bus.a_col_i    = 32'h04030201;
        bus.b_row_i    = 32'h04030201;
        step();
        clear_inputs();
        check("t1_ready_drop", bus.in_ready_o, 0);
        for (int c = 1; c <= 8; c++) begin
            if (c > 1) step();
            exp_v = (c <= 4) ? (32'(c) << (8 * (c - 1))) : 32'h0;
            check("t1_a", bus.a_o, exp_v);
            check("t1_b", bus.b_o, exp_v);
            check("t1_done", bus.done_o, (c == 7));
        end

        // 2: K=3 with valid held high
        bus.start_i    = 1'b1;
        bus.k_len_i    = 9'd3;
        bus.in_valid_i = 1'b1;
        bus.a_col_i    = 32'h11223344;
        bus.b_row_i    = 32'h55667788;
        step();
        bus.start_i = 1'b0;
        ready_cnt = 0; busy_cnt = 0; done_cnt = 0; done_cyc = 0;
        for (int c = 1; c <= 12; c++) begin
            if (bus.in_ready_o) ready_cnt++;
            if (bus.busy_o) busy_cnt++;
            if (bus.done_o) begin
                done_cnt++;
                done_cyc = c;
            end
            step();
        end
        clear_inputs();
        check("t2_ready_cycles", 64'(ready_cnt), 3);
        check("t2_busy_cycles",  64'(busy_cnt), 9);
        check("t2_done_pulses",  64'(done_cnt), 1);
        check("t2_done_cycle",   64'(done_cyc), 10);

        // 3: K=2 with three bubbles between beats
        bus.start_i = 1'b1;
        bus.k_len_i = 9'd2;
        step();
        bus.start_i    = 1'b0;
        bus.in_valid_i = 1'b1;
        bus.a_col_i    = 32'h11111111;
        bus.b_row_i    = 32'h11111111;
        for (int c = 1; c <= 12; c++) begin
            step();
            check("t3_lane3", bus.a_o[31:24], (c == 4) ? 8'h11 : (c == 8) ? 8'h22 : 8'h00);
            check("t3_lane0", bus.a_o[7:0],   (c == 1) ? 8'h11 : (c == 5) ? 8'h22 : 8'h00);
            check("t3_done",  bus.done_o, (c == 11));
            bus.in_valid_i = (c == 4);
            bus.a_col_i    = (c == 4) ? 32'h22222222 : 32'h0;
            bus.b_row_i    = (c == 4) ? 32'h22222222 : 32'h0;
        end
`ifdef FEEDER_BUBBLE_CNT_EN
        exp_bub = 16'd3;
`else
        exp_bub = 16'd0;
`endif
        check("t3_bubbles", bus.bubble_cnt_o, exp_bub);

        // 4: K=0 goes straight to DONE
        bus.start_i = 1'b1;
        bus.k_len_i = 9'd0;
        step();
        bus.start_i = 1'b0;
        check("t4_done",  bus.done_o, 1);
        check("t4_ready", bus.in_ready_o, 0);
        check("t4_a",     bus.a_o, 0);
        step();
        check("t4_done_end", bus.done_o, 0);
        check("t4_ready2",   bus.in_ready_o, 0);
        check("t4_b",        bus.b_o, 0);

        // 5: reset after the first of four beats
        bus.start_i = 1'b1;
        bus.k_len_i = 9'd4;
        step();
        bus.start_i    = 1'b0;
        bus.in_valid_i = 1'b1;
        bus.a_col_i    = 32'h55555555;
        bus.b_row_i    = 32'h55555555;
        step();
        check("t5_lane0_pre", bus.a_o[7:0], 8'h55);
        clear_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t5_ready", bus.in_ready_o, 0);
        check("t5_busy",  bus.busy_o, 0);
        check("t5_done",  bus.done_o, 0);
        check("t5_a",     bus.a_o, 0);
        check("t5_b",     bus.b_o, 0);
        done_cnt = 0;
        for (int c = 0; c < 8; c++) begin
            if (bus.done_o) done_cnt++;
            step();
        end
        check("t5_no_done", 64'(done_cnt), 0);
        bus.start_i = 1'b1;
        bus.k_len_i = 9'd1;
        step();
        bus.start_i    = 1'b0;
        bus.in_valid_i = 1'b1;
        bus.a_col_i    = 32'h0D0C0B0A;
        bus.b_row_i    = 32'h0D0C0B0A;
        step();
        clear_inputs();
        for (int c = 1; c <= 7; c++) begin
            if (c > 1) step();
            if (c == 4) check("t5_lane3", bus.b_o[31:24], 8'h0D);
            check("t5_done2", bus.done_o, (c == 7));
        end

        // 6: start in FEED and valid in FLUSH/IDLE are ignored
        step();
        bus.start_i = 1'b1;
        bus.k_len_i = 9'd2;
        step();
        bus.k_len_i    = 9'd5;
        bus.in_valid_i = 1'b1;
        bus.a_col_i    = 32'h0A0A0A0A;
        step();
        bus.a_col_i = 32'h0B0B0B0B;
        step();
        bus.start_i = 1'b0;
        bus.a_col_i = 32'hEEEEEEEE;
        bus.b_row_i = 32'hEEEEEEEE;
        for (int c = 1; c <= 8; c++) begin
            if (c > 1) step();
            exp_v = '0;
            for (int i = 0; i < 4; i++) begin
                if (c == i + 1) exp_v[i*8 +: 8] = 8'h0B;
                else if (c == i) exp_v[i*8 +: 8] = 8'h0A;
            end
            check("t6_a", bus.a_o, exp_v);
            check("t6_done", bus.done_o, (c == 7));
        end
        step();
        step();
        check("t6_idle_a",     bus.a_o, 0);
        check("t6_idle_b",     bus.b_o, 0);
        check("t6_idle_ready", bus.in_ready_o, 0);
        check("t6_idle_busy",  bus.busy_o, 0);
        clear_inputs();

        // 6b: K=300 clamps to 256 beats
        bus.start_i    = 1'b1;
        bus.k_len_i    = 9'd300;
        bus.in_valid_i = 1'b1;
        bus.a_col_i    = 32'h01010101;
        bus.b_row_i    = 32'h01010101;
        step();
        bus.start_i = 1'b0;
        ready_cnt = 0;
        done_cyc  = 0;
        for (int c = 1; c <= 400; c++) begin
            if (bus.in_ready_o) ready_cnt++;
            if (bus.done_o) begin
                done_cyc = c;
                break;
            end
            step();
        end
        clear_inputs();
        check("t6_clamp_beats", 64'(ready_cnt), 256);
        check("t6_clamp_done",  64'(done_cyc), 263);
        check("t6_clamp_bub",   bus.bubble_cnt_o, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
